// File: rtl/ecc_decoder.sv
// ecc_decoder: Hamming (16,11) SECDED decoder with byte-serial input and output.
// A codeword arrives as two bytes (low first), is checked and corrected in one
// decode cycle, and leaves as two bytes carrying the data word and a 2-bit status.
// Saturating counters record corrected and uncorrectable words for software.
module ecc_decoder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic [7:0] corr_cnt,
  output logic [7:0] uncorr_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    RX_LO  = 3'd0,
    RX_HI  = 3'd1,
    DECODE = 3'd2,
    TX_LO  = 3'd3,
    TX_HI  = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_OK     = 2'b00;
  localparam logic [1:0] STATUS_CORR   = 2'b01;
  localparam logic [1:0] STATUS_UNCORR = 2'b10;

  state_t      state;
  state_t      next_state;

  logic [7:0]  lo_byte;
  logic [7:0]  hi_byte;
  logic [10:0] data_reg;
  logic [1:0]  status_reg;

  logic [15:0] codeword;
  logic [3:0]  syndrome;
  logic        parity;
  logic [15:0] corrected;
  logic [10:0] dec_data;
  logic [1:0]  dec_status;

  assign codeword = {hi_byte, lo_byte};

  // State register; reset abandons any partially received or pending word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RX_LO;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the handshake strobes, which depend on state alone.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      RX_LO: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RX_HI;
      end
      RX_HI: begin
        in_ready = 1'b1;
        if (in_valid) next_state = DECODE;
      end
      DECODE: begin
        next_state = TX_LO;
      end
      TX_LO: begin
        out_valid = 1'b1;
        if (out_ready) next_state = TX_HI;
      end
      TX_HI: begin
        out_valid = 1'b1;
        if (out_ready) next_state = RX_LO;
      end
      default: begin
        next_state = RX_LO;
      end
    endcase
  end

  // Syndrome, overall parity, single-bit correction and data extraction.
  // A set overall parity means an odd number of flips, so the syndrome names
  // the bad bit (zero points at the overall parity bit itself); an even count
  // with a nonzero syndrome is a double error and the word is passed through.
  always_comb begin
    syndrome = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (codeword[i]) syndrome = syndrome ^ 4'(i);
    end
    parity    = ^codeword;
    corrected = codeword;
    if (parity) begin
      corrected[syndrome] = ~codeword[syndrome];
    end
    dec_data = {corrected[15:9], corrected[7:5], corrected[3]};
    if (parity) begin
      dec_status = STATUS_CORR;
    end else if (syndrome != 4'd0) begin
      dec_status = STATUS_UNCORR;
    end else begin
      dec_status = STATUS_OK;
    end
  end

  // Byte capture, result registers and the registered output byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lo_byte    <= 8'h00;
      hi_byte    <= 8'h00;
      data_reg   <= 11'd0;
      status_reg <= 2'b00;
      out_byte   <= 8'h00;
    end else begin
      case (state)
        RX_LO: begin
          if (in_valid) lo_byte <= in_byte;
        end
        RX_HI: begin
          if (in_valid) hi_byte <= in_byte;
        end
        DECODE: begin
          data_reg   <= dec_data;
          status_reg <= dec_status;
          out_byte   <= dec_data[7:0];
        end
        TX_LO: begin
          if (out_ready) out_byte <= {status_reg, 3'b000, data_reg[10:8]};
        end
        TX_HI: begin
          if (out_ready) out_byte <= 8'h00;
        end
        default: begin
          out_byte <= 8'h00;
        end
      endcase
    end
  end

  // Saturating error counters, bumped once per decoded word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      corr_cnt   <= 8'd0;
      uncorr_cnt <= 8'd0;
    end else if (state == DECODE) begin
      if (dec_status == STATUS_CORR && corr_cnt != 8'hFF) begin
        corr_cnt <= corr_cnt + 8'd1;
      end
      if (dec_status == STATUS_UNCORR && uncorr_cnt != 8'hFF) begin
        uncorr_cnt <= uncorr_cnt + 8'd1;
      end
    end
  end

  // Busy flag registered from the upcoming state so it tracks state exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state != RX_LO);
    end
  end

endmodule

// File: tb/tb_ecc_decoder.sv
// tb_ecc_decoder: directed vector table, hand-written corner sequences and
// randomized words checked against an encode-and-inject reference model.
module tb_ecc_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_byte = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte;
  logic [7:0] corr_cnt;
  logic [7:0] uncorr_cnt;
  logic       busy;

  localparam int BUDGET = 50;

  int check_count = 0;
  int pass_count  = 0;
  int exp_corr    = 0;
  int exp_uncorr  = 0;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] exp_lo;
    logic [7:0] exp_hi;
    int         corr_inc;
    int         uncorr_inc;
    string      name;
  } vector_t;

  vector_t vectors [8];

  ecc_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Position of data bit k: the k-th codeword index that is not zero and not a power of two.
  function automatic int data_pos(input int k);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) res = p;
        n++;
      end
    end
    return res;
  endfunction

  // Build a valid codeword: Hamming parity makes the XOR of set indices zero, bit 0 evens the word.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    int          s;
    cw = '0;
    s  = 0;
    for (int k = 0; k < 11; k++) begin
      if (d[k]) begin
        cw[data_pos(k)] = 1'b1;
        s = s ^ data_pos(k);
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (s[j]) cw[1 << j] = 1'b1;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    d = '0;
    for (int k = 0; k < 11; k++) d[k] = cw[data_pos(k)];
    return d;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    check_count++;
    $display("[TB] FAIL %s: timed out after %0d cycles, expected handshake", name, BUDGET);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int cycles;
    cycles   = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!in_ready) timeoutFail("in_ready wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic applyStimulus(input logic [7:0] lo, input logic [7:0] hi, input int gap);
    sendByte(lo);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    sendByte(hi);
  endtask

  task automatic receiveByte(input logic [7:0] exp, input string name);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!out_valid) begin
      timeoutFail(name);
    end else begin
      compare(name, 32'(out_byte), 32'(exp));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic checkOutput(input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                             input string name, input int stall);
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    receiveByte(exp_lo, {name, " lo"});
    receiveByte(exp_hi, {name, " hi"});
  endtask

  task automatic bumpCounters(input int corr_inc, input int uncorr_inc);
    if (corr_inc != 0 && exp_corr < 255) exp_corr++;
    if (uncorr_inc != 0 && exp_uncorr < 255) exp_uncorr++;
  endtask

  task automatic checkCounters(input string name);
    compare({name, " corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
    compare({name, " uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
  endtask

  // Random word: encode random data, inject 0, 1 or 2 flips, and expect what was injected.
  task automatic randomWord(input int kind, input string name);
    logic [10:0] d;
    logic [15:0] cw;
    logic [10:0] exp_d;
    logic [1:0]  exp_st;
    int          a;
    int          b;
    d      = 11'($urandom);
    cw     = encode(d);
    exp_d  = d;
    exp_st = 2'b00;
    if (kind == 1) begin
      a      = $urandom_range(0, 15);
      cw[a]  = ~cw[a];
      exp_st = 2'b01;
    end else if (kind == 2) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      cw[a]  = ~cw[a];
      cw[b]  = ~cw[b];
      exp_d  = extract(cw);
      exp_st = 2'b10;
    end
    applyStimulus(cw[7:0], cw[15:8], $urandom_range(0, 2));
    checkOutput(exp_d[7:0], {exp_st, 3'b000, exp_d[10:8]}, name, $urandom_range(0, 3));
    bumpCounters(kind == 1 ? 1 : 0, kind == 2 ? 1 : 0);
    checkCounters(name);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    exp_corr   = 0;
    exp_uncorr = 0;
  endtask

  // Main test sequence.
  initial begin
    logic [7:0] held;

    vectors[0] = '{8'hFF, 8'hFF, 8'hFF, 8'h07, 0, 0, "clean 7FF"};
    vectors[1] = '{8'h20, 8'h00, 8'h00, 8'h40, 1, 0, "single pos5"};
    vectors[2] = '{8'h01, 8'h00, 8'h00, 8'h40, 1, 0, "single pos0"};
    vectors[3] = '{8'h28, 8'h00, 8'h03, 8'h80, 0, 1, "double pos3+5"};
    vectors[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "clean zero"};
    vectors[5] = '{8'h00, 8'h80, 8'h00, 8'h40, 1, 0, "single pos15"};
    vectors[6] = '{8'h03, 8'h00, 8'h00, 8'h80, 0, 1, "double pos0+1"};
    vectors[7] = '{8'hF7, 8'hFF, 8'hFF, 8'h47, 1, 0, "single pos3 on 7FF"};

    doReset();
    compare("reset in_ready", 32'(in_ready), 32'd1);
    compare("reset out_valid", 32'(out_valid), 32'd0);
    compare("reset out_byte", 32'(out_byte), 32'h00);
    compare("reset busy", 32'(busy), 32'd0);
    checkCounters("reset");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i].lo, vectors[i].hi, 0);
      if (i == 0) begin
        compare("decode busy", 32'(busy), 32'd1);
        compare("decode in_ready", 32'(in_ready), 32'd0);
        compare("decode out_valid", 32'(out_valid), 32'd0);
      end
      checkOutput(vectors[i].exp_lo, vectors[i].exp_hi, vectors[i].name, 0);
      compare({vectors[i].name, " idle out_byte"}, 32'(out_byte), 32'h00);
      bumpCounters(vectors[i].corr_inc, vectors[i].uncorr_inc);
      checkCounters(vectors[i].name);
    end

    // Backpressure: TX_LO held for five cycles with out_ready low.
    applyStimulus(8'h28, 8'h00, 0);
    @(posedge clk);
    #1;
    compare("bp out_valid", 32'(out_valid), 32'd1);
    held = out_byte;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      compare("bp out_byte stable", 32'(out_byte), 32'(held));
      compare("bp in_ready", 32'(in_ready), 32'd0);
    end
    checkOutput(8'h03, 8'h80, "bp", 0);
    bumpCounters(0, 1);
    checkCounters("bp");

    // Idle cycles between the two input bytes give the same result.
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput(8'hFF, 8'h07, "gap", 0);
    checkCounters("gap");

    // Reset while waiting for the high byte drops the partial word.
    sendByte(8'h20);
    compare("rx_hi busy", 32'(busy), 32'd1);
    doReset();
    compare("mid reset busy", 32'(busy), 32'd0);
    compare("mid reset out_valid", 32'(out_valid), 32'd0);
    checkCounters("mid reset");
    applyStimulus(8'h00, 8'h00, 0);
    checkOutput(8'h00, 8'h00, "post reset", 0);
    checkCounters("post reset");

    // Randomized mix of clean, single and double error words.
    for (int w = 0; w < 60; w++) begin
      randomWord($urandom_range(0, 2), "random");
    end

    // Saturation: 300 single-error words after a fresh reset.
    doReset();
    for (int w = 0; w < 300; w++) begin
      randomWord(1, "saturate");
    end
    compare("saturated corr_cnt", 32'(corr_cnt), 32'd255);
    compare("saturated uncorr_cnt", 32'(uncorr_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
